// File: rtl/core_seq_pkg.sv
// Shared types for the core sequencer: FSM state encoding and PC-select codes.
package core_seq_pkg;

  localparam int PC_SEL_W = 2;

  typedef enum logic [2:0] {
    CLEAR  = 3'd0,
    LOAD   = 3'd1,
    FETCH  = 3'd2,
    DECODE = 3'd3,
    EXEC   = 3'd4,
    MEM    = 3'd5,
    WB     = 3'd6,
    HALT   = 3'd7
  } seq_state_e;

  typedef enum logic [PC_SEL_W-1:0] {
    PC_PLUS4  = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JALR   = 2'd2,
    PC_JAL    = 2'd3
  } pc_sel_e;

  // JALR outranks JAL, which outranks a taken branch.
  function automatic pc_sel_e pick_pc_sel(input logic jalre, input logic uje,
                                          input logic be, input logic taken);
    pc_sel_e sel;
    if (jalre)            sel = PC_JALR;
    else if (uje)         sel = PC_JAL;
    else if (be && taken) sel = PC_BRANCH;
    else                  sel = PC_PLUS4;
    return sel;
  endfunction

endpackage

// File: rtl/core_sequencer_boot_loader.sv
// Program-image loader: valid/ready word stream into instruction memory,
// with a done pulse on the last word or when memory is full.
module boot_loader #(
  parameter int IMEM_DEPTH = 256,
  localparam int AW = $clog2(IMEM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          active,
  input  logic          load_valid,
  input  logic          load_last,
  input  logic [31:0]   load_data,
  output logic          load_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          done
);

  logic [AW-1:0] addr;
  logic          accept;
  logic          full;

  // A word transfers when load_valid and load_ready are both high in a cycle.
  assign load_ready = active;
  assign accept     = active && load_valid;
  assign full       = (addr == AW'(IMEM_DEPTH - 1));
  assign done       = accept && (load_last || full);

  assign imem_we    = accept;
  assign imem_addr  = addr;
  assign imem_wdata = load_data;

  // Address saturates at the top word; the FSM leaves LOAD on that write.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      addr <= '0;
    end else if (accept && !full) begin
      addr <= addr + 1'b1;
    end
  end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle core sequencer: CLEAR, LOAD, then FETCH/DECODE/EXEC/[MEM]/WB.
// Optional retired-instruction counter enabled by CORE_SEQ_PERF_EN.
module core_sequencer
  import core_seq_pkg::*;
#(
  parameter int IMEM_DEPTH = 256,
  localparam int AW = $clog2(IMEM_DEPTH)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_valid_i,
  output logic                load_ready_o,
  input  logic [31:0]         load_data_i,
  input  logic                load_last_i,
  output logic [AW-1:0]       imem_addr_o,
  output logic [31:0]         imem_wdata_o,
  output logic                imem_we_o,
  output logic                regrst_o,
  output logic                ir_en_o,
  input  logic                rwr_en_i,
  input  logic                be_i,
  input  logic                jalre_i,
  input  logic                uje_i,
  input  logic                mem_op_i,
  input  logic                illegal_i,
  input  logic                branch_taken_i,
  output logic                rwr_en_o,
  output logic                pc_en_o,
  output logic [PC_SEL_W-1:0] pc_sel_o,
  output logic                mem_req_o,
  input  logic                mem_ready_i,
  output logic                halted_o,
`ifdef CORE_SEQ_PERF_EN
  output logic [31:0]         retired_o,
`endif
  output logic [2:0]          state_o
);

  seq_state_e state;
  logic       load_done;

  boot_loader #(.IMEM_DEPTH(IMEM_DEPTH)) u_boot_loader (
    .clk        (clk_i),
    .rst        (rst_i),
    .clear      (state == CLEAR),
    .active     (state == LOAD),
    .load_valid (load_valid_i),
    .load_last  (load_last_i),
    .load_data  (load_data_i),
    .load_ready (load_ready_o),
    .imem_we    (imem_we_o),
    .imem_addr  (imem_addr_o),
    .imem_wdata (imem_wdata_o),
    .done       (load_done)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= CLEAR;
    end else begin
      case (state)
        CLEAR:  state <= LOAD;
        LOAD:   if (load_done) state <= FETCH;
        FETCH:  state <= DECODE;
        DECODE: state <= illegal_i ? HALT : EXEC;
        EXEC:   state <= mem_op_i ? MEM : WB;
        MEM:    if (mem_ready_i) state <= WB;
        WB:     state <= FETCH;
        HALT:   state <= HALT;
      endcase
    end
  end

  // Decoder enables only reach the datapath in WB.
  assign regrst_o  = (state == CLEAR);
  assign ir_en_o   = (state == FETCH);
  assign mem_req_o = (state == MEM);
  assign rwr_en_o  = (state == WB) && rwr_en_i;
  assign pc_en_o   = (state == WB);
  assign pc_sel_o  = (state == WB) ? pick_pc_sel(jalre_i, uje_i, be_i, branch_taken_i)
                                   : PC_PLUS4;
  assign halted_o  = (state == HALT);
  assign state_o   = state;

`ifdef CORE_SEQ_PERF_EN
  logic [31:0] retired;

  always_ff @(posedge clk_i) begin
    if (rst_i || state == CLEAR) begin
      retired <= '0;
    end else if (state == WB) begin
      retired <= retired + 32'd1;
    end
  end

  assign retired_o = retired;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: a 256-word instance for the main flow
// and a 4-word instance for the memory-full load case.
module tb_core_sequencer;
  import core_seq_pkg::*;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- main instance (IMEM_DEPTH = 256) ----------------
  logic        rst, load_valid, load_last, rwr_en_in, be, jalre, uje, mem_op, illegal, taken, mem_ready;
  logic [31:0] load_data;
  logic        load_ready, imem_we, regrst, ir_en, rwr_en, pc_en, mem_req, halted;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [1:0]  pc_sel;
  logic [2:0]  state;
`ifdef CORE_SEQ_PERF_EN
  logic [31:0] retired;
`endif

  core_sequencer #(.IMEM_DEPTH(256)) dut (
    .clk_i(clk), .rst_i(rst), .load_valid_i(load_valid), .load_ready_o(load_ready),
    .load_data_i(load_data), .load_last_i(load_last), .imem_addr_o(imem_addr),
    .imem_wdata_o(imem_wdata), .imem_we_o(imem_we), .regrst_o(regrst), .ir_en_o(ir_en),
    .rwr_en_i(rwr_en_in), .be_i(be), .jalre_i(jalre), .uje_i(uje), .mem_op_i(mem_op),
    .illegal_i(illegal), .branch_taken_i(taken), .rwr_en_o(rwr_en), .pc_en_o(pc_en),
    .pc_sel_o(pc_sel), .mem_req_o(mem_req), .mem_ready_i(mem_ready), .halted_o(halted),
`ifdef CORE_SEQ_PERF_EN
    .retired_o(retired),
`endif
    .state_o(state)
  );

  // ---------------- small instance (IMEM_DEPTH = 4) ----------------
  logic        rst_s, load_valid_s, load_last_s, zero_s;
  logic [31:0] load_data_s;
  logic        load_ready_s, imem_we_s, regrst_s, ir_en_s, rwr_en_s, pc_en_s, mem_req_s, halted_s;
  logic [1:0]  imem_addr_s, pc_sel_s;
  logic [31:0] imem_wdata_s;
  logic [2:0]  state_s;
`ifdef CORE_SEQ_PERF_EN
  logic [31:0] retired_s;
`endif

  core_sequencer #(.IMEM_DEPTH(4)) dut_s (
    .clk_i(clk), .rst_i(rst_s), .load_valid_i(load_valid_s), .load_ready_o(load_ready_s),
    .load_data_i(load_data_s), .load_last_i(load_last_s), .imem_addr_o(imem_addr_s),
    .imem_wdata_o(imem_wdata_s), .imem_we_o(imem_we_s), .regrst_o(regrst_s), .ir_en_o(ir_en_s),
    .rwr_en_i(zero_s), .be_i(zero_s), .jalre_i(zero_s), .uje_i(zero_s), .mem_op_i(zero_s),
    .illegal_i(zero_s), .branch_taken_i(zero_s), .rwr_en_o(rwr_en_s), .pc_en_o(pc_en_s),
    .pc_sel_o(pc_sel_s), .mem_req_o(mem_req_s), .mem_ready_i(zero_s), .halted_o(halted_s),
`ifdef CORE_SEQ_PERF_EN
    .retired_o(retired_s),
`endif
    .state_o(state_s)
  );

  // ---------------- scoreboards ----------------
  logic [12:0] exp_q[$];     // per-cycle expected control outputs
  logic [39:0] wr_q[$];      // expected {addr, data} imem writes, main instance
  logic [39:0] wr_q_s[$];    // same, small instance
  int          exp_ret = 0;

  wire [12:0] obs   = {state, regrst, load_ready, imem_we, ir_en, rwr_en, pc_en, pc_sel, mem_req, halted};
  wire [12:0] obs_s = {state_s, regrst_s, load_ready_s, imem_we_s, ir_en_s, rwr_en_s, pc_en_s,
                       pc_sel_s, mem_req_s, halted_s};

  function automatic logic [12:0] ev(input logic [2:0] st, input logic rr, input logic rdy,
                                     input logic we, input logic ir, input logic rw,
                                     input logic pe, input logic [1:0] sel,
                                     input logic mq, input logic hl);
    return {st, rr, rdy, we, ir, rw, pe, sel, mq, hl};
  endfunction

  always @(negedge clk) begin
    logic [39:0] w;
    if (imem_we === 1'b1) begin
      if (wr_q.size() == 0) check("wr_extra", 32'd1, 32'd0);
      else begin
        w = wr_q.pop_front();
        check("wr_addr", {24'd0, imem_addr}, {24'd0, w[39:32]});
        check("wr_data", imem_wdata, w[31:0]);
      end
    end
    if (imem_we_s === 1'b1) begin
      if (wr_q_s.size() == 0) check("wr_extra_s", 32'd1, 32'd0);
      else begin
        w = wr_q_s.pop_front();
        check("wr_addr_s", {30'd0, imem_addr_s}, {24'd0, w[39:32]});
        check("wr_data_s", imem_wdata_s, w[31:0]);
      end
    end
  end

  // Inputs are set at posedge+1; outputs are compared at the following negedge.
  task automatic step(input string tag, input logic [12:0] exp);
    exp_q.push_back(exp);
    @(negedge clk);
    check(tag, {19'd0, obs}, {19'd0, exp_q.pop_front()});
    @(posedge clk); #1;
  endtask

  task automatic step_s(input string tag, input logic [12:0] exp);
    exp_q.push_back(exp);
    @(negedge clk);
    check(tag, {19'd0, obs_s}, {19'd0, exp_q.pop_front()});
    @(posedge clk); #1;
  endtask

  task automatic rand_dec();
    rwr_en_in = 1'($urandom_range(0, 1));
    be        = 1'($urandom_range(0, 1));
    jalre     = 1'($urandom_range(0, 1));
    uje       = 1'($urandom_range(0, 1));
    taken     = 1'($urandom_range(0, 1));
    mem_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic load_word(input logic [7:0] addr, input logic last);
    load_valid = 1'b1;
    load_last  = last;
    load_data  = $urandom;
    wr_q.push_back({addr, load_data});
    step("load", ev(LOAD, 0, 1, 1, 0, 0, 0, 2'd0, 0, 0));
  endtask

  task automatic front_end(input logic is_mem);
    rand_dec(); illegal = 1'($urandom_range(0, 1)); mem_op = 1'($urandom_range(0, 1));
    step("fetch", ev(FETCH, 0, 0, 0, 1, 0, 0, 2'd0, 0, 0));
    rand_dec(); illegal = 1'b0; mem_op = 1'($urandom_range(0, 1));
    step("decode", ev(DECODE, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0));
    rand_dec(); illegal = 1'($urandom_range(0, 1)); mem_op = is_mem;
    step("exec", ev(EXEC, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0));
  endtask

  task automatic wb(input logic rw, input logic jr, input logic uj, input logic b,
                    input logic tk, input logic [1:0] sel);
    rwr_en_in = rw; jalre = jr; uje = uj; be = b; taken = tk;
    illegal = 1'($urandom_range(0, 1)); mem_op = 1'($urandom_range(0, 1));
    step("wb", ev(WB, 0, 0, 0, 0, rw, 1, sel, 0, 0));
    exp_ret++;
  endtask

  task automatic run_alu(input logic rw, input logic jr, input logic uj, input logic b,
                         input logic tk, input logic [1:0] sel);
    front_end(1'b0);
    wb(rw, jr, uj, b, tk, sel);
  endtask

  task automatic run_mem(input int waits, input logic rw);
    front_end(1'b1);
    for (int i = 0; i < waits; i++) begin
      rand_dec(); mem_ready = 1'b0;
      step("mem_wait", ev(MEM, 0, 0, 0, 0, 0, 0, 2'd0, 1, 0));
    end
    rand_dec(); mem_ready = 1'b1;
    step("mem_done", ev(MEM, 0, 0, 0, 0, 0, 0, 2'd0, 1, 0));
    wb(rw, 0, 0, 0, 0, 2'd0);
  endtask

  initial begin
    rst = 1'b1; load_valid = 0; load_last = 0; load_data = '0;
    rwr_en_in = 0; be = 0; jalre = 0; uje = 0; mem_op = 0; illegal = 0; taken = 0; mem_ready = 0;
    rst_s = 1'b1; load_valid_s = 0; load_last_s = 0; load_data_s = '0; zero_s = 1'b0;

    // Reset held for three edges, then one CLEAR cycle after release.
    @(posedge clk); #1;
    step("rst_hold", ev(CLEAR, 1, 0, 0, 0, 0, 0, 2'd0, 0, 0));
    step("rst_hold", ev(CLEAR, 1, 0, 0, 0, 0, 0, 2'd0, 0, 0));
    rst = 1'b0;
    step("rst_after", ev(CLEAR, 1, 0, 0, 0, 0, 0, 2'd0, 0, 0));
    step("load_idle", ev(LOAD, 0, 1, 0, 0, 0, 0, 2'd0, 0, 0));

    for (int i = 0; i < 4; i++) load_word(8'(i), i == 3);
    load_valid = 1'b0; load_last = 1'b0;

    // ADDI, then the PC-select priority cases.
    run_alu(1, 0, 0, 0, 0, 2'd0);
    run_alu(0, 1, 1, 1, 1, 2'd2);
    run_alu(0, 0, 0, 1, 0, 2'd0);
    run_alu(1, 0, 1, 1, 1, 2'd3);
    run_alu(0, 0, 0, 1, 1, 2'd1);

    // Load with three wait cycles, then a random wait.
    run_mem(3, 1'b1);
    run_mem($urandom_range(0, 4), 1'b0);

    // Reset pulsed while MEM is waiting.
    front_end(1'b1);
    rand_dec(); mem_ready = 1'b0;
    step("mem_wait", ev(MEM, 0, 0, 0, 0, 0, 0, 2'd0, 1, 0));
    rst = 1'b1; mem_ready = 1'b0;
    step("mem_rst", ev(MEM, 0, 0, 0, 0, 0, 0, 2'd0, 1, 0));
    rst = 1'b0; exp_ret = 0;
    step("rst_mid_mem", ev(CLEAR, 1, 0, 0, 0, 0, 0, 2'd0, 0, 0));

    load_word(8'd0, 1'b0);
    load_word(8'd1, 1'b1);
    load_valid = 1'b0; load_last = 1'b0;
    run_alu(1, 0, 0, 0, 0, 2'd0);

    // Illegal instruction halts; nothing further is strobed.
    rand_dec(); illegal = 1'($urandom_range(0, 1)); mem_op = 1'($urandom_range(0, 1));
    step("fetch", ev(FETCH, 0, 0, 0, 1, 0, 0, 2'd0, 0, 0));
    rand_dec(); illegal = 1'b1;
    step("decode_ill", ev(DECODE, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0));
    for (int i = 0; i < 5; i++) begin
      rand_dec(); illegal = 1'($urandom_range(0, 1)); mem_op = 1'($urandom_range(0, 1));
      rwr_en_in = 1'b1; load_valid = 1'b1;
      step("halt", ev(HALT, 0, 0, 0, 0, 0, 0, 2'd0, 0, 1));
    end
    load_valid = 1'b0;
`ifdef CORE_SEQ_PERF_EN
    check("retired_frozen", retired, 32'(exp_ret));
`endif

    // Small memory: six words offered without last, only four accepted.
    rst_s = 1'b0;
    step_s("s_clear", ev(CLEAR, 1, 0, 0, 0, 0, 0, 2'd0, 0, 0));
    load_valid_s = 1'b1;
    for (int i = 0; i < 6; i++) begin
      load_data_s = $urandom;
      if (i < 4) begin
        wr_q_s.push_back({8'(i), load_data_s});
        step_s("s_load", ev(LOAD, 0, 1, 1, 0, 0, 0, 2'd0, 0, 0));
      end else if (i == 4) begin
        step_s("s_fetch", ev(FETCH, 0, 0, 0, 1, 0, 0, 2'd0, 0, 0));
      end else begin
        step_s("s_decode", ev(DECODE, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0));
      end
    end
    load_valid_s = 1'b0;

    check("wr_q_left", 32'(wr_q.size()), 32'd0);
    check("wr_q_s_left", 32'(wr_q_s.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
